// File: rtl/lock_pkg.sv
// Shared definitions for the password-lock key path: key codes, the key FSM
// state type and the key-vector helpers used by the front end and the digit stage.
package lock_pkg;

    localparam int NUM_KEYS = 11;

    localparam logic [3:0] KEY_NONE = 4'd0;
    localparam logic [3:0] KEY_DEL  = 4'd10;
    localparam logic [3:0] KEY_CLR  = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        MULTI
    } key_state_t;

    // True when exactly one key in the vector is pressed.
    function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

    // Key code of a one-hot key vector: bits 0..8 are digits 1..9,
    // bit 9 is delete, bit 10 is clear. Only meaningful for one-hot input.
    function automatic logic [3:0] encode_key(input logic [NUM_KEYS-1:0] v);
        logic [3:0] code;
        code = KEY_NONE;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) begin
                code = 4'(i + 1);
            end
        end
        if (v[9]) begin
            code = KEY_DEL;
        end
        if (v[10]) begin
            code = KEY_CLR;
        end
        return code;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a whole-vector stability filter: the
// debounced output only follows the synchronised vector after it has been
// unchanged for DEBOUNCE_CYCLES consecutive cycles.
module sync_debounce #(
    parameter int W               = 11,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] raw_in,
    output logic [W-1:0] deb_out
);

    // The counter saturates at DEBOUNCE_CYCLES-1, so that value must fit in CNT_W bits.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce_cfg
        $error("sync_debounce: DEBOUNCE_CYCLES must be in 2..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     sync1_q, sync1_d;
    logic [W-1:0]     sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     deb_q, deb_d;

    // Synchroniser shift, stability count (restarts whenever s is about to
    // change) and acceptance of s once it has been stable long enough.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        if (sync1_q != sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset means "all keys released".
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            deb_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
        end
    end

    assign deb_out = deb_q;

endmodule

// File: rtl/key_debounce_encoder.sv
// Keypad front end: normalises the raw keys to an active-high vector,
// debounces it and turns each clean single-key press into one key event.
// Optional delete auto-repeat is built when KEY_REPEAT_EN is defined.
module key_debounce_encoder
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] number_input,
    input  logic       delete_input,
    input  logic       clear_input,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    // Repeat timing must allow a reload value of REPEAT_DELAY-REPEAT_PERIOD.
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat_cfg
        $error("key_debounce_encoder: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
    end

    logic [NUM_KEYS-1:0] raw_vec;
    logic [NUM_KEYS-1:0] deb_vec;

    assign raw_vec = {clear_input, delete_input, ~number_input};

    sync_debounce #(
        .W               (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .clock   (clock),
        .reset   (reset),
        .raw_in  (raw_vec),
        .deb_out (deb_vec)
    );

    key_state_t          state_q, state_d;
    logic [NUM_KEYS-1:0] pressed_q, pressed_d;
    logic                key_valid_q, key_valid_d;
    logic [3:0]          key_code_q, key_code_d;
    logic                key_held_q, key_held_d;

`ifdef KEY_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_MAX    = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    // Key FSM: one event on entry to PRESSED from IDLE, anything else waits
    // for a full debounced release; delete may auto-repeat while held.
    always_comb begin
        state_d     = state_q;
        pressed_d   = pressed_q;
        key_valid_d = 1'b0;
        key_code_d  = KEY_NONE;
        key_held_d  = (deb_vec != '0);
`ifdef KEY_REPEAT_EN
        rpt_cnt_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (deb_vec != '0) begin
                    if (is_one_hot(deb_vec)) begin
                        key_valid_d = 1'b1;
                        key_code_d  = encode_key(deb_vec);
                        pressed_d   = deb_vec;
                        state_d     = PRESSED;
                    end else begin
                        state_d = MULTI;
                    end
                end
            end
            PRESSED: begin
                if (deb_vec == '0) begin
                    state_d = IDLE;
                end else if (deb_vec != pressed_q) begin
                    state_d = MULTI;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (encode_key(pressed_q) == KEY_DEL) begin
                        if (rpt_cnt_q == RPT_MAX) begin
                            key_valid_d = 1'b1;
                            key_code_d  = KEY_DEL;
                            rpt_cnt_d   = RPT_RELOAD;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        end
                    end
`endif
                end
            end
            MULTI: begin
                if (deb_vec == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered FSM state and outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pressed_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= KEY_NONE;
            key_held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pressed_q   <= pressed_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
`ifdef KEY_REPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
`endif
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule

// File: doc/key_debounce_encoder.md
Name: key_debounce_encoder

Overview:
- Front-end stage of the password lock.
- Synchronises and debounces the 9 digit keys (active-low), the delete button and the clear button (active-high).
- Emits exactly one single-cycle key event per clean press, with a 4-bit key code.
- Feeds the keypad event decoder / digit shift stage that fills the four password digit registers.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronised input vector must stay unchanged before it is accepted; legal range 2..2^CNT_W-1.
- CNT_W, 16: width of the stability counter.
- REPEAT_DELAY, 25000000: cycles delete must be held before the first auto-repeat (only with KEY_REPEAT_EN).
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeats (only with KEY_REPEAT_EN).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- number_input  in  9  raw digit keys, active-low; bit i pressed means digit i+1.
- delete_input  in  1  raw delete button, active-high.
- clear_input  in  1  raw clear button, active-high.
- key_valid  out  1  one-cycle strobe: a new key event.
- key_code  out  4  1..9 digit, 10 delete, 11 clear; 0 whenever key_valid=0.
- key_held  out  1  debounced "some key pressed" level.

Behaviour:
- **Normalisation.** Raw inputs form an 11-bit active-high vector r = {clear, delete, ~number_input}.
- **Synchroniser.** r passes a 2-FF synchroniser, giving s. Reset values: all zeros, i.e. released.
- **Stability counter.** cnt clears to 0 when s differs from its previous-cycle value; otherwise it increments, saturating at DEBOUNCE_CYCLES-1.
- **Debounced vector.** d loads s on the edge where cnt == DEBOUNCE_CYCLES-1 and s is unchanged. Glitches shorter than DEBOUNCE_CYCLES never reach d.
- **FSM on d:**
  - IDLE:
    - d==0: stay.
    - d one-hot: key_valid=1 for exactly one cycle with its code, go PRESSED.
    - d multi-hot: go MULTI, no event.
  - PRESSED:
    - d==0: go IDLE.
    - d changes to another nonzero value: go MULTI, no event.
    - d unchanged: stay.
  - MULTI:
    - d==0: go IDLE.
    - Otherwise stay. No events until full release.
- **One event per press.** A key must return through IDLE, i.e. debounced release, before it can produce another event.
- **Latency.** key_valid is registered. Raw press held stably is first sampled at edge k; key_valid is high in the cycle after edge k+DEBOUNCE_CYCLES+2. Release latency to key_held=0 is the same.
- **Code encoding.**
  - d bit i (i=0..8) gives code i+1.
  - d bit 9 gives 10.
  - d bit 10 gives 11.
  - Simultaneous keys never produce a code; there is no priority.
- **key_held** equals (d != 0).
- **Reset values.**
  - Outputs: key_valid=0, key_code=0, key_held=0.
  - Internal: state IDLE, cnt=0, d=0, synchroniser=0.
- **Reset mid-press.**
  - A key still held when reset deasserts is debounced afresh.
  - It produces one event DEBOUNCE_CYCLES+3 cycles later, because the reset state is "released".
- **Counter width.** Counter never wraps (saturation). DEBOUNCE_CYCLES must not exceed 2^CNT_W-1; checked by an elaboration-time assertion.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined:
  - In PRESSED with code 10 (delete), a repeat counter starts at entry.
  - After REPEAT_DELAY cycles, emit key_valid/key_code=10, then one more every REPEAT_PERIOD cycles while d is unchanged.
  - The counter resets on leaving PRESSED. Digits and clear never repeat.
- Undefined: no repeat counter is instantiated; exactly one event per press for every key.

Decomposition:
- **Package lock_pkg:**
  - Constants KEY_NONE=4'd0, KEY_DEL=4'd10, KEY_CLR=4'd11, NUM_KEYS=11.
  - FSM state typedef {IDLE, PRESSED, MULTI}.
  - Shared with the downstream digit stage.
- **Sub-module sync_debounce:** parameterised width W plus DEBOUNCE_CYCLES/CNT_W. Contains the 2-FF synchroniser, stability counter and d register.
- **Top:** FSM, encoder and optional repeat logic.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5):
1. Reset, then number_input=9'h1FB held 20 cycles then released → one key_valid with key_code=3, high in the cycle after edge k+6; key_held high until 7 cycles after release; no second strobe.
2. number_input bit0 bounces (low 2 cycles, high 1, low 2, then low steady) → exactly one key_code=1 event, timed from the last bounce edge.
3. delete_input=1 and number_input=9'h1FE asserted on the same edge, held 10 cycles, released → no key_valid, key_held=1 during hold; subsequent clean clear press gives key_code=11.
4. Press digit 9 (9'h0FF), and 10 cycles later also press delete while still holding 9 → one code-9 event only, state MULTI, nothing until both released.
5. Hold digit 5, assert reset for 2 cycles mid-hold, keep holding → outputs 0 during reset; one code-5 event 7 cycles after reset deasserts.
6. With KEY_REPEAT_EN, hold delete 40 cycles → events at press latency, +20, +25, +30, +35, all key_code=10; without the macro → single event.
